input_repeat_scheduler: RTL and testbench
=========================================

// Module: input_repeat_scheduler
// PURPOSE
//  Converts debounced button levels into discrete game commands for the tetris core.
//  Per button: one event on press, then optional auto-repeat (initial delay DAS, then every ARR).
//  Pending events from all buttons are shared onto one valid/ready command port by round-robin.
//  Sits between the debouncer outputs and the game-logic move/rotate controller.
// PARAMETERS
//  N_BTN      4    number of buttons (index = tetris_input_pkg::btn_e)
//  DAS_CYCLES 16   cycles from press event to first repeat event (>=2)
//  ARR_CYCLES 4    cycles between subsequent repeat events (>=1)
//  CNT_W      16   width of per-button delay counter; must hold max(DAS_CYCLES,ARR_CYCLES)
// PORTS
//  clk            in   1              system clock, single domain
//  rst            in   1              asynchronous, active-high reset
//  btn_level      in   N_BTN          debounced button levels, 1 = pressed
//  repeat_en      in   N_BTN          per-button auto-repeat enable, sampled every cycle
//  cmd_valid      out  1              command available
//  cmd_ready      in   1              consumer accepts command when valid&ready
//  cmd_id         out  $clog2(N_BTN)  button index of command
//  cmd_repeat     out  1              1 = generated by auto-repeat, 0 = initial press
//  overflow       out  1              sticky: an event was dropped
//  clr_overflow   in   1              synchronous clear of overflow
// BEHAVIOUR
//  Reset: cmd_valid=0, cmd_id=0, cmd_repeat=0, overflow=0, all pending=0, all FSMs IDLE,
//   counters=0, rr pointer=0, btn_prev='1 (button held through reset gives no event until released).
//  Per-button FSM (IDLE, DELAY, REPEAT, HELD):
//   IDLE: btn_level=1 & btn_prev=0 -> press event; to DELAY if repeat_en else HELD; cnt=0.
//   DELAY: cnt++; cnt==DAS_CYCLES-1 -> repeat event, cnt=0, to REPEAT.
//   REPEAT: cnt++; cnt==ARR_CYCLES-1 -> repeat event, cnt=0.
//   HELD: no events while held.
//   Any state, btn_level=0 -> IDLE, cnt=0, no event. repeat_en=0 in DELAY/REPEAT -> HELD.
//   repeat_en 0->1 while HELD has no effect until next press.
//  Event -> pending[i]=1, pend_rep[i]=event type. Event while pending[i]=1 and not granted
//   this cycle: event dropped, overflow<=1, pending contents unchanged.
//  Grant same cycle as new event for same button: new event is latched (set wins), no overflow.
//  Arbiter: output register loads when cmd_valid=0 or (cmd_valid&cmd_ready).
//   Winner = first pending index at or after rr pointer, wrapping; pointer <= winner+1 mod N_BTN.
//   Loads cmd_id, cmd_repeat; clears pending[winner]; cmd_valid=1. No pending -> cmd_valid<=0 on accept.
//  cmd_valid/cmd_id/cmd_repeat stable while cmd_valid&!cmd_ready.
//  Latency: btn_level first sampled high at edge t -> pending at t, cmd_valid at edge t+1 (if output free).
//  Throughput: one command per cycle with cmd_ready held 1.
//  overflow: clr_overflow and a drop in same cycle -> overflow stays 1 (set wins).
//  rst mid-operation: immediate return to reset values; in-flight command discarded.
// STRUCTURE
//  tetris_input_pkg: btn_e (BTN_LEFT=0, BTN_RIGHT=1, BTN_ROT=2, BTN_DROP=3), N_BTN,
//   default DAS/ARR constants, rpt_state_e {IDLE,DELAY,REPEAT,HELD}.
//  Sub-module btn_repeat_fsm (one per button, generate loop): btn_prev, FSM, counter,
//   outputs evt and evt_repeat for one cycle. Top holds pending bits, arbiter, output register.
// TESTING (bench uses DAS_CYCLES=4, ARR_CYCLES=2, N_BTN=4)
//  Single tap: btn_level[1] high 2 cycles, ready=1 -> exactly one cmd id=1 repeat=0; nothing else.
//  Hold: btn_level[0] high 12 cycles, repeat_en=1 -> cmd id=0 rep=0, then rep=1 4 cycles later,
//   then rep=1 every 2 cycles until release; no cmd after release drains.
//  Simultaneous press of buttons 0,2,3 same cycle, ready=1 -> ids 0,2,3 on consecutive cycles;
//   second simultaneous press of 0 and 2 with pointer=0 -> order 0,2 (rr fairness).
//  Backpressure: ready=0, hold btn 0 with repeat_en=1 -> first cmd held stable, one pending,
//   next repeat sets overflow=1; clr_overflow -> 0; ready=1 drains exactly 2 commands.
//  repeat_en=0 held 20 cycles -> exactly one command; btn held across rst deassert -> no command.
//  Async rst asserted mid-repeat while cmd_valid=1 -> cmd_valid=0 immediately, no command after.

Source files
------------

// File: rtl/tetris_input_pkg.sv
// Shared types and default timing constants for the tetris button input path.
package tetris_input_pkg;

    typedef enum logic [1:0] {
        BTN_LEFT  = 2'd0,
        BTN_RIGHT = 2'd1,
        BTN_ROT   = 2'd2,
        BTN_DROP  = 2'd3
    } btn_e;

    localparam int N_BTN       = 4;
    localparam int DAS_DEFAULT = 16;
    localparam int ARR_DEFAULT = 4;
    localparam int CNT_W_DEFAULT = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2,
        HELD   = 2'd3
    } rpt_state_e;

endpackage

// File: rtl/btn_repeat_fsm.sv
// One button: press-edge event, then optional auto-repeat after DAS and every ARR cycles.
// evt/evt_repeat are combinational and valid for the cycle in which the event occurs.
module btn_repeat_fsm #(
    parameter int DAS_CYCLES = 16,
    parameter int ARR_CYCLES = 4,
    parameter int CNT_W      = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_level,
    input  logic repeat_en,
    output logic evt,
    output logic evt_repeat
);
    import tetris_input_pkg::*;

    localparam logic [CNT_W-1:0] DAS_LAST = CNT_W'(DAS_CYCLES - 1);
    localparam logic [CNT_W-1:0] ARR_LAST = CNT_W'(ARR_CYCLES - 1);

    rpt_state_e       state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             btn_prev;

    // btn_prev resets high so a button held through reset must be released first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            btn_prev <= 1'b1;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            btn_prev <= btn_level;
        end
    end

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        evt        = 1'b0;
        evt_repeat = 1'b0;
        if (!btn_level) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!btn_prev) begin
                        evt       = 1'b1;
                        cnt_nxt   = '0;
                        state_nxt = repeat_en ? DELAY : HELD;
                    end
                end
                DELAY: begin
                    if (!repeat_en) begin
                        state_nxt = HELD;
                        cnt_nxt   = '0;
                    end else if (cnt == DAS_LAST) begin
                        evt        = 1'b1;
                        evt_repeat = 1'b1;
                        cnt_nxt    = '0;
                        state_nxt  = REPEAT;
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
                REPEAT: begin
                    if (!repeat_en) begin
                        state_nxt = HELD;
                        cnt_nxt   = '0;
                    end else if (cnt == ARR_LAST) begin
                        evt        = 1'b1;
                        evt_repeat = 1'b1;
                        cnt_nxt    = '0;
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
                HELD: begin
                    state_nxt = HELD;
                end
                default: begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/input_repeat_scheduler.sv
// Turns debounced button levels into press/repeat commands, shared round-robin onto one
// command port. Per-button timing lives in btn_repeat_fsm; this level holds pending bits.
module input_repeat_scheduler #(
    parameter int N_BTN      = tetris_input_pkg::N_BTN,
    parameter int DAS_CYCLES = tetris_input_pkg::DAS_DEFAULT,
    parameter int ARR_CYCLES = tetris_input_pkg::ARR_DEFAULT,
    parameter int CNT_W      = tetris_input_pkg::CNT_W_DEFAULT,
    localparam int IDW       = (N_BTN > 1) ? $clog2(N_BTN) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_level,
    input  logic [N_BTN-1:0] repeat_en,
    output logic             cmd_valid,
    input  logic             cmd_ready,
    output logic [IDW-1:0]   cmd_id,
    output logic             cmd_repeat,
    output logic             overflow,
    input  logic             clr_overflow
);

    logic [N_BTN-1:0] evt, evt_rep;
    logic [N_BTN-1:0] pending, pend_rep;
    logic [N_BTN-1:0] grant;
    logic [IDW-1:0]   rr_ptr, rr_nxt, win_idx;
    logic             win_found, load, drop_any;
    int               scan_idx;

    for (genvar i = 0; i < N_BTN; i++) begin : g_btn
        btn_repeat_fsm #(
            .DAS_CYCLES (DAS_CYCLES),
            .ARR_CYCLES (ARR_CYCLES),
            .CNT_W      (CNT_W)
        ) u_fsm (
            .clk        (clk),
            .rst        (rst),
            .btn_level  (btn_level[i]),
            .repeat_en  (repeat_en[i]),
            .evt        (evt[i]),
            .evt_repeat (evt_rep[i])
        );
    end

    // Handshake: a command transfers on a cycle where cmd_valid && cmd_ready; while
    // cmd_valid && !cmd_ready, cmd_valid/cmd_id/cmd_repeat hold their values.
    assign load = !cmd_valid || cmd_ready;

    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        scan_idx  = 0;
        grant     = '0;
        drop_any  = 1'b0;
        for (int k = 0; k < N_BTN; k++) begin
            scan_idx = (int'(rr_ptr) + k) % N_BTN;
            if (!win_found && pending[scan_idx]) begin
                win_found = 1'b1;
                win_idx   = IDW'(scan_idx);
            end
        end
        grant[win_idx] = load && win_found;
        rr_nxt = (win_idx == IDW'(N_BTN - 1)) ? '0 : win_idx + IDW'(1);
        // An event can only be stored if its slot is empty or being emptied this cycle.
        for (int i = 0; i < N_BTN; i++) begin
            if (evt[i] && pending[i] && !grant[i]) drop_any = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending    <= '0;
            pend_rep   <= '0;
            rr_ptr     <= '0;
            cmd_valid  <= 1'b0;
            cmd_id     <= '0;
            cmd_repeat <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            for (int i = 0; i < N_BTN; i++) begin
                if (evt[i] && !(pending[i] && !grant[i])) begin
                    pending[i]  <= 1'b1;
                    pend_rep[i] <= evt_rep[i];
                end else if (grant[i]) begin
                    pending[i] <= 1'b0;
                end
            end
            if (load) begin
                cmd_valid <= win_found;
                if (win_found) begin
                    cmd_id     <= win_idx;
                    cmd_repeat <= pend_rep[win_idx];
                    rr_ptr     <= rr_nxt;
                end
            end
            if (drop_any) begin
                overflow <= 1'b1;
            end else if (clr_overflow) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_input_repeat_scheduler.sv
// Bench for input_repeat_scheduler: directed scenarios plus random stimulus, checked
// against a cycle-level behavioural model through an expected-command queue.
`timescale 1ns/1ps
module tb_input_repeat_scheduler;

    localparam int NB  = 4;
    localparam int DAS = 4;
    localparam int ARR = 2;

    // clock / reset
    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NB-1:0] btn_level = '0;
    logic [NB-1:0] repeat_en = '0;
    logic          cmd_ready = 1'b0;
    logic          clr_overflow = 1'b0;
    logic          cmd_valid, cmd_repeat, overflow;
    logic [1:0]    cmd_id;

    always #5 clk = ~clk;

    input_repeat_scheduler #(
        .N_BTN      (NB),
        .DAS_CYCLES (DAS),
        .ARR_CYCLES (ARR),
        .CNT_W      (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .btn_level    (btn_level),
        .repeat_en    (repeat_en),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_id       (cmd_id),
        .cmd_repeat   (cmd_repeat),
        .overflow     (overflow),
        .clr_overflow (clr_overflow)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string nm, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // scoreboard: expected {id, repeat} pushed by the model when a command is issued
    logic [2:0] exp_q[$];

    // reference model: a button's event times follow from its age since the press edge
    int m_age[NB];
    bit m_rok[NB], m_prev[NB], m_pend[NB], m_prep[NB];
    bit ev[NB], er[NB];
    bit m_valid, m_rep, m_ov, ld, drop;
    int m_id, m_ptr, w, j;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NB; i++) begin
                m_age[i] = 0; m_rok[i] = 0; m_prev[i] = 1; m_pend[i] = 0; m_prep[i] = 0;
            end
            m_valid = 0; m_rep = 0; m_ov = 0; m_id = 0; m_ptr = 0;
            exp_q.delete();
        end else begin
            for (int i = 0; i < NB; i++) begin
                ev[i] = 0; er[i] = 0;
                if (btn_level[i]) begin
                    if (!m_prev[i]) begin
                        m_age[i] = 0; m_rok[i] = repeat_en[i]; ev[i] = 1;
                    end else begin
                        m_age[i]++;
                        if (!repeat_en[i]) m_rok[i] = 0;
                        if (m_rok[i] && m_age[i] >= DAS && (m_age[i] - DAS) % ARR == 0) begin
                            ev[i] = 1; er[i] = 1;
                        end
                    end
                end else begin
                    m_rok[i] = 0;
                end
                m_prev[i] = btn_level[i];
            end
            ld = !m_valid || cmd_ready;
            w = -1;
            if (ld) begin
                for (int k = 0; k < NB; k++) begin
                    j = (m_ptr + k) % NB;
                    if (w < 0 && m_pend[j]) w = j;
                end
                if (w >= 0) begin
                    m_valid = 1; m_id = w; m_rep = m_prep[w];
                    exp_q.push_back(3'(w * 2 + int'(m_prep[w])));
                    m_ptr = (w + 1) % NB;
                end else begin
                    m_valid = 0;
                end
            end
            drop = 0;
            for (int i = 0; i < NB; i++) begin
                if (ev[i]) begin
                    if (m_pend[i] && w != i) drop = 1;
                    else begin m_pend[i] = 1; m_prep[i] = er[i]; end
                end else if (w == i) begin
                    m_pend[i] = 0;
                end
            end
            if (drop) m_ov = 1;
            else if (clr_overflow) m_ov = 0;
        end
    end

    // monitor: compares outputs on the falling edge and logs accepted commands
    int cyc_n = 0;
    int acc_ids[$], acc_reps[$], acc_cyc[$];
    logic [2:0] e;

    always @(negedge clk) begin
        cyc_n++;
        chk("cmd_valid", int'(cmd_valid), int'(m_valid));
        chk("overflow", int'(overflow), int'(m_ov));
        if (m_valid) chk("cmd_fields", int'({cmd_id, cmd_repeat}), m_id * 2 + int'(m_rep));
        if (cmd_valid && cmd_ready && !rst) begin
            chk("cmd_expected", int'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("cmd_scoreboard", int'({cmd_id, cmd_repeat}), int'(e));
            end
            acc_ids.push_back(int'(cmd_id));
            acc_reps.push_back(int'(cmd_repeat));
            acc_cyc.push_back(cyc_n);
        end
    end

    // driver tasks
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        acc_ids.delete(); acc_reps.delete(); acc_cyc.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc(2);
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        cyc(3);
        chk("rst_valid", int'(cmd_valid), 0);
        chk("rst_id", int'(cmd_id), 0);
        chk("rst_repeat", int'(cmd_repeat), 0);
        chk("rst_overflow", int'(overflow), 0);
        rst = 1'b0;
        cyc(2);

        // simultaneous press with pointer at 0, then a second pair
        cmd_ready = 1'b1; repeat_en = '0; clear_log();
        btn_level = 4'b1101; cyc(2); btn_level = '0; cyc(6);
        chk("sim_count", acc_ids.size(), 3);
        if (acc_ids.size() == 3) begin
            chk("sim_id0", acc_ids[0], 0); chk("sim_id1", acc_ids[1], 2);
            chk("sim_id2", acc_ids[2], 3); chk("sim_gap", acc_cyc[2] - acc_cyc[0], 2);
        end
        clear_log();
        btn_level = 4'b0101; cyc(2); btn_level = '0; cyc(6);
        chk("rr_count", acc_ids.size(), 2);
        if (acc_ids.size() == 2) begin
            chk("rr_id0", acc_ids[0], 0); chk("rr_id1", acc_ids[1], 2);
        end

        // single tap
        repeat_en = '1; clear_log();
        btn_level = 4'b0010; cyc(2); btn_level = '0; cyc(6);
        chk("tap_count", acc_ids.size(), 1);
        if (acc_ids.size() == 1) begin
            chk("tap_id", acc_ids[0], 1); chk("tap_rep", acc_reps[0], 0);
        end

        // hold with auto-repeat
        clear_log();
        btn_level = 4'b0001; cyc(12); btn_level = '0; cyc(6);
        chk("hold_count", acc_ids.size(), 5);
        if (acc_ids.size() == 5) begin
            chk("hold_rep0", acc_reps[0], 0);
            chk("hold_rep4", acc_reps[4], 1);
            chk("hold_das", acc_cyc[1] - acc_cyc[0], DAS);
            chk("hold_arr", acc_cyc[2] - acc_cyc[1], ARR);
            chk("hold_arr2", acc_cyc[4] - acc_cyc[3], ARR);
        end

        // backpressure and overflow
        cmd_ready = 1'b0; clear_log();
        btn_level = 4'b0001; cyc(7); btn_level = '0;
        chk("bp_overflow_set", int'(overflow), 1);
        chk("bp_valid_held", int'(cmd_valid), 1);
        chk("bp_id_held", int'({cmd_id, cmd_repeat}), 0);
        clr_overflow = 1'b1; cyc(1); clr_overflow = 1'b0;
        chk("bp_overflow_clr", int'(overflow), 0);
        cmd_ready = 1'b1; cyc(6);
        chk("bp_drain_count", acc_ids.size(), 2);

        // repeat disabled
        repeat_en = '0; clear_log();
        btn_level = 4'b1000; cyc(20); btn_level = '0; cyc(4);
        chk("norep_count", acc_ids.size(), 1);

        // held across reset
        clear_log();
        btn_level = 4'b0100; do_reset(); cyc(8); btn_level = '0; cyc(4);
        chk("held_rst_count", acc_ids.size(), 0);

        // async reset mid-repeat while a command is waiting
        repeat_en = '1; cmd_ready = 1'b0;
        btn_level = 4'b0001; cyc(6);
        chk("ar_valid_before", int'(cmd_valid), 1);
        #2 rst = 1'b1;
        #1 chk("ar_valid_async", int'(cmd_valid), 0);
        btn_level = '0; clear_log(); cmd_ready = 1'b1;
        cyc(2); rst = 1'b0; cyc(8);
        chk("ar_after_count", acc_ids.size(), 0);

        // random phase
        for (int c = 0; c < 600; c++) begin
            for (int b = 0; b < NB; b++) begin
                if ($urandom_range(0, 5) == 0) btn_level[b] = ~btn_level[b];
                if ($urandom_range(0, 19) == 0) repeat_en[b] = ~repeat_en[b];
            end
            cmd_ready = ($urandom_range(0, 3) != 0);
            clr_overflow = ($urandom_range(0, 15) == 0);
            cyc(1);
        end
        btn_level = '0; cmd_ready = 1'b1; clr_overflow = 1'b0;
        cyc(10);
        chk("final_queue_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
